pudding_dac_loader: RTL and testbench
=====================================

// Module: pudding_dac_loader
// PURPOSE
//  Parametrised serial loader and state register for the current-steering DAC array.
//  Successor of the fixed 128-cell shift/transfer chain. Adds:
//   - generic cell count
//   - binary-to-thermometer load mode
//   - rate-limited ramp mode
//   - shift-frame counting
//   - synchronised enable
//  Sits between pad inputs and the DAC unit-cell ON/ONB and EN inverter drivers.
// PARAMETERS
//  N_CELLS  128                     number of unit current cells (state bits)
//  N_EN     4                       number of enable lines driven to the array
//  TAP_W    8                       width of chain/state readback taps (<= N_CELLS)
//  CODE_W   $clog2(N_CELLS+1)       binary code width in thermometer/ramp modes
//  RAMP_DIV 16                      clk cycles per ramp step (>=1)
// PORTS
//  clk         in   1         clock, all logic on rising edge
//  rst_n       in   1         asynchronous active-low reset
//  datum       in   1         serial data in
//  shift       in   1         shift enable: chain <= {chain[N_CELLS-2:0],datum}
//  transfer    in   1         transfer strobe (level, acts every cycle high)
//  dir         in   1         1: chain->state, 0: state->chain (readback)
//  mode        in   2         00 direct, 01 thermometer, 10 ramp, 11 = 00
//  en_in       in   1         asynchronous array enable request
//  state_o     out  N_CELLS   cell ON vector to the array
//  en_o        out  N_EN      synchronised enable, replicated
//  chain_tap_o out  TAP_W     chain[N_CELLS-1 -: TAP_W]
//  state_tap_o out  TAP_W     state_o[N_CELLS-1 -: TAP_W]
//  frame_ok_o  out  1         required number of bits shifted since last transfer
//  busy_o      out  1         ramp in progress
// BEHAVIOUR
//  Reset (async): every register and output is 0.
//   - chain, state_o, count, target, shift_cnt, divider cleared; FSM -> IDLE.
//  Priority each cycle:
//   - transfer beats shift; chain does not shift in a transfer cycle.
//   - Ramp stepping runs independently of shift and transfer.
//  Transfer, dir=1:
//   - mode 00: state_o <= chain.
//   - mode 01: code = chain[CODE_W-1:0], saturated to N_CELLS.
//     count <= code; state_o <= thermometer(code), i.e. bits [code-1:0] set, LSB first.
//   - mode 10: target <= saturated code; FSM -> RAMP; count and state unchanged.
//   - Any mode: shift_cnt <= 0.
//  Transfer, dir=0:
//   - mode 00: chain <= state_o.
//   - mode 01/10: chain <= {0, count}.
//   - shift_cnt unchanged.
//  shift_cnt:
//   - Saturating counter, increments on each accepted shift.
//   - frame_ok_o = shift_cnt >= (mode 00 ? N_CELLS : CODE_W), registered.
//  Ramp FSM IDLE/RAMP:
//   - In RAMP, the divider counts 0..RAMP_DIV-1. On wrap, count moves 1 toward target.
//   - state_o is updated to thermometer(count) in the same cycle, so one cell changes per step.
//   - When count==target, go to IDLE; busy_o low the next cycle.
//   - busy_o = (FSM==RAMP).
//   - Transfer dir=1 during RAMP: target re-latched, divider kept, ramp continues from current count.
//     Reversal is allowed.
//   - Any transfer with mode!=10 aborts the ramp to IDLE; the transfer then acts normally.
//   - Target equal to current count: enter RAMP, exit after first divider wrap with no cell change.
//  Enable:
//   - en_in passes through a 2-flop synchroniser; en_o = {N_EN{en_sync}}, 2-cycle latency.
//  Outputs are registered; no combinational path from inputs to outputs.
//  Reset mid-ramp or mid-shift: immediate clear, no partial update survives.
// TESTING
//  Direct: reset; shift 128 bits 0xA5.. pattern; transfer dir=1.
//   -> state_o == pattern, frame_ok_o=1 before transfer, 0 after.
//  Readback: mode 00, transfer dir=0 then shift 8.
//   -> chain_tap_o shows state bits in order; state_o unchanged.
//  Thermometer: mode 01, shift code 37, transfer dir=1.
//   -> state_o == (1<<37)-1.
//   -> code 200 saturates to all 128 ones.
//  Ramp: count=0; mode 10, code 5, RAMP_DIV=16.
//   -> one extra cell every 16 clk; busy_o high 80 cycles; final state_o == 5'h1F.
//   -> Retarget to 2 at count 4 ramps down to 2.
//  Priority/abort: shift and transfer high together -> no shift.
//   -> Mode 01 transfer mid-ramp -> busy_o low, state = thermometer(new code).
//  Async reset asserted mid-ramp with en_in=1.
//   -> all outputs 0 same cycle.
//   -> en_o returns 2 cycles after release.

Source files
------------

// File: rtl/pudding_dac_loader.sv
// Serial shift/transfer loader and cell-state register for the current-steering DAC array,
// with direct, binary-to-thermometer and rate-limited ramp load modes plus a synchronised enable.
module pudding_dac_loader #(
   parameter int unsigned N_CELLS  = 128,
   parameter int unsigned N_EN     = 4,
   parameter int unsigned TAP_W    = 8,
   parameter int unsigned CODE_W   = $clog2(N_CELLS + 1),
   parameter int unsigned RAMP_DIV = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               datum,
   input  logic               shift,
   input  logic               transfer,
   input  logic               dir,
   input  logic [1:0]         mode,
   input  logic               en_in,
   output logic [N_CELLS-1:0] state_o,
   output logic [N_EN-1:0]    en_o,
   output logic [TAP_W-1:0]   chain_tap_o,
   output logic [TAP_W-1:0]   state_tap_o,
   output logic               frame_ok_o,
   output logic               busy_o
);

   localparam int unsigned       DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(RAMP_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
   localparam logic [CODE_W-1:0] N_CODE   = CODE_W'(N_CELLS);
   localparam logic [CODE_W-1:0] CODE_ONE = CODE_W'(1);
   localparam logic [CODE_W-1:0] CODE_LEN = CODE_W'(CODE_W);

   typedef enum logic {
      IDLE,
      RAMP
   } ramp_state_e;

   ramp_state_e         fsm_q, fsm_d;
   logic [N_CELLS-1:0]  chain_q, chain_d;
   logic [N_CELLS-1:0]  state_q, state_d;
   logic [CODE_W-1:0]   count_q, count_d;
   logic [CODE_W-1:0]   target_q, target_d;
   logic [CODE_W-1:0]   shift_cnt_q, shift_cnt_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic                frame_ok_q, frame_ok_d;
   logic                en_s1_q, en_s2_q;

   logic [CODE_W-1:0]   sat_code;
   logic [CODE_W-1:0]   frame_len;
   logic                mode_therm, mode_ramp, abort;

   function automatic logic [N_CELLS-1:0] therm(input logic [CODE_W-1:0] c);
      logic [N_CELLS-1:0] t;
      t = '0;
      for (int unsigned i = 0; i < N_CELLS; i++) begin
         t[i] = (i < 32'(c));
      end
      return t;
   endfunction

   always_comb begin
      fsm_d       = fsm_q;
      chain_d     = chain_q;
      state_d     = state_q;
      count_d     = count_q;
      target_d    = target_q;
      shift_cnt_d = shift_cnt_q;
      div_d       = div_q;

      mode_therm = (mode == 2'b01);
      mode_ramp  = (mode == 2'b10);
      sat_code   = (chain_q[CODE_W-1:0] > N_CODE) ? N_CODE : chain_q[CODE_W-1:0];
      frame_len  = (mode_therm || mode_ramp) ? CODE_LEN : N_CODE;
      abort      = transfer && !mode_ramp;

      if (fsm_q == RAMP && !abort) begin
         if (div_q == DIV_MAX) begin
            div_d = '0;
            if (count_q == target_q) begin
               fsm_d = IDLE;
            end else begin
               count_d = (count_q < target_q) ? count_q + CODE_ONE : count_q - CODE_ONE;
               state_d = therm(count_d);
               if (count_d == target_q) fsm_d = IDLE;
            end
         end else begin
            div_d = div_q + DIV_ONE;
         end
      end

      if (abort) begin
         fsm_d = IDLE;
         div_d = '0;
      end

      // A mode-10 load re-arms the ramp even if the old target was just reached this cycle.
      if (transfer) begin
         if (dir) begin
            shift_cnt_d = '0;
            if (mode_ramp) begin
               target_d = sat_code;
               fsm_d    = RAMP;
            end else if (mode_therm) begin
               count_d = sat_code;
               state_d = therm(sat_code);
            end else begin
               state_d = chain_q;
            end
         end else begin
            if (mode_therm || mode_ramp) begin
               chain_d               = '0;
               chain_d[CODE_W-1:0]   = count_q;
            end else begin
               chain_d = state_q;
            end
         end
      end else if (shift) begin
         chain_d = {chain_q[N_CELLS-2:0], datum};
         if (shift_cnt_q != N_CODE) shift_cnt_d = shift_cnt_q + CODE_ONE;
      end

      frame_ok_d = (shift_cnt_d >= frame_len);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q       <= IDLE;
         chain_q     <= '0;
         state_q     <= '0;
         count_q     <= '0;
         target_q    <= '0;
         shift_cnt_q <= '0;
         div_q       <= '0;
         frame_ok_q  <= 1'b0;
         en_s1_q     <= 1'b0;
         en_s2_q     <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         chain_q     <= chain_d;
         state_q     <= state_d;
         count_q     <= count_d;
         target_q    <= target_d;
         shift_cnt_q <= shift_cnt_d;
         div_q       <= div_d;
         frame_ok_q  <= frame_ok_d;
         en_s1_q     <= en_in;
         en_s2_q     <= en_s1_q;
      end
   end

   assign state_o     = state_q;
   assign en_o        = {N_EN{en_s2_q}};
   assign chain_tap_o = chain_q[N_CELLS-1 -: TAP_W];
   assign state_tap_o = state_q[N_CELLS-1 -: TAP_W];
   assign frame_ok_o  = frame_ok_q;
   assign busy_o      = (fsm_q == RAMP);

endmodule

// File: tb/tb_pudding_dac_loader.sv
// Directed bench for pudding_dac_loader: direct load, readback, thermometer, ramp,
// priority/abort and asynchronous reset, all against hand-computed values.
module tb_pudding_dac_loader;

   logic         clk;
   logic         rst_n;
   logic         datum;
   logic         shift;
   logic         transfer;
   logic         dir;
   logic [1:0]   mode;
   logic         en_in;
   logic [127:0] state_o;
   logic [3:0]   en_o;
   logic [7:0]   chain_tap_o;
   logic [7:0]   state_tap_o;
   logic         frame_ok_o;
   logic         busy_o;

   int unsigned  checks;
   int unsigned  errors;
   logic [127:0] pat;

   pudding_dac_loader #(
      .N_CELLS (128),
      .N_EN    (4),
      .TAP_W   (8),
      .CODE_W  (8),
      .RAMP_DIV(16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .datum      (datum),
      .shift      (shift),
      .transfer   (transfer),
      .dir        (dir),
      .mode       (mode),
      .en_in      (en_in),
      .state_o    (state_o),
      .en_o       (en_o),
      .chain_tap_o(chain_tap_o),
      .state_tap_o(state_tap_o),
      .frame_ok_o (frame_ok_o),
      .busy_o     (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] thermo(input int unsigned n);
      return (128'd1 << n) - 128'd1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         shift = 1'b1;
         datum = b[i];
         tick();
      end
      shift = 1'b0;
      datum = 1'b0;
   endtask

   task automatic xfer(input logic d, input logic [1:0] m);
      transfer = 1'b1;
      dir      = d;
      mode     = m;
      tick();
      transfer = 1'b0;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      datum    = 1'b0;
      shift    = 1'b0;
      transfer = 1'b0;
      dir      = 1'b0;
      mode     = 2'b00;
      en_in    = 1'b0;
      pat      = {16{8'hA5}};

      #12;
      check("rst_state", state_o, '0);
      check("rst_busy", busy_o, 0);
      check("rst_frame", frame_ok_o, 0);
      check("rst_en", en_o, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // direct load of the A5 pattern, MSB first
      for (int i = 127; i >= 0; i--) begin
         shift = 1'b1;
         datum = pat[i];
         tick();
      end
      shift = 1'b0;
      check("dir_frame_before", frame_ok_o, 1);
      check("dir_chain_tap", chain_tap_o, 8'hA5);
      xfer(1'b1, 2'b00);
      check("dir_state", state_o, pat);
      check("dir_state_tap", state_tap_o, 8'hA5);
      check("dir_frame_after", frame_ok_o, 0);

      // readback into the chain, then walk it out
      xfer(1'b0, 2'b00);
      check("rb_tap0", chain_tap_o, 8'hA5);
      shift_byte(8'h00);
      check("rb_tap8", chain_tap_o, 8'hA5);
      check("rb_state", state_o, pat);
      check("rb_frame", frame_ok_o, 0);
      xfer(1'b0, 2'b00);
      shift = 1'b1;
      tick();
      check("rb_tap1", chain_tap_o, 8'h4B);
      repeat (4) tick();
      shift = 1'b0;
      check("rb_tap5", chain_tap_o, 8'hB4);

      // thermometer mode
      mode = 2'b01;
      shift_byte(8'd37);
      check("th_frame", frame_ok_o, 1);
      xfer(1'b1, 2'b01);
      check("th_37", state_o, thermo(37));
      check("th_tap", state_tap_o, 8'h00);
      shift_byte(8'd200);
      xfer(1'b1, 2'b01);
      check("th_sat", state_o, {128{1'b1}});

      // ramp 0 -> 5, one cell every 16 clocks
      shift_byte(8'd0);
      xfer(1'b1, 2'b01);
      check("rp_zero", state_o, '0);
      shift_byte(8'd5);
      xfer(1'b1, 2'b10);
      check("rp_busy0", busy_o, 1);
      check("rp_state0", state_o, '0);
      for (int k = 1; k <= 5; k++) begin
         repeat (15) tick();
         check("rp_hold", state_o, thermo(k - 1));
         check("rp_busy", busy_o, 1);
         tick();
         check("rp_step", state_o, thermo(k));
      end
      check("rp_done_busy", busy_o, 0);
      check("rp_final", state_o, 128'h1F);

      // ramp 0 -> 5, retarget to 2 at count 4
      shift_byte(8'd0);
      xfer(1'b1, 2'b01);
      shift_byte(8'd5);
      xfer(1'b1, 2'b10);
      shift_byte(8'd2);
      repeat (56) tick();
      check("rt_at4", state_o, thermo(4));
      xfer(1'b1, 2'b10);
      check("rt_busy", busy_o, 1);
      repeat (14) tick();
      check("rt_hold4", state_o, thermo(4));
      tick();
      check("rt_step3", state_o, thermo(3));
      repeat (15) tick();
      check("rt_hold3", state_o, thermo(3));
      check("rt_busy3", busy_o, 1);
      tick();
      check("rt_step2", state_o, thermo(2));
      check("rt_done", busy_o, 0);

      // shift and transfer together: no shift
      xfer(1'b0, 2'b00);
      shift    = 1'b1;
      datum    = 1'b1;
      transfer = 1'b1;
      dir      = 1'b1;
      mode     = 2'b00;
      tick();
      shift    = 1'b0;
      transfer = 1'b0;
      datum    = 1'b0;
      xfer(1'b1, 2'b00);
      check("prio_noshift", state_o, thermo(2));

      // mode-01 transfer aborts a running ramp
      shift_byte(8'd6);
      xfer(1'b1, 2'b10);
      check("ab_busy", busy_o, 1);
      repeat (16) tick();
      check("ab_step", state_o, thermo(3));
      shift_byte(8'd9);
      xfer(1'b1, 2'b01);
      check("ab_idle", busy_o, 0);
      check("ab_state", state_o, thermo(9));
      repeat (20) tick();
      check("ab_stay", state_o, thermo(9));
      check("ab_stay_busy", busy_o, 0);

      // enable synchroniser and async reset mid-ramp
      en_in = 1'b1;
      tick();
      check("en_lat1", en_o, 4'h0);
      tick();
      check("en_lat2", en_o, 4'hF);
      shift_byte(8'd0);
      xfer(1'b1, 2'b10);
      repeat (20) tick();
      check("rs_mid", state_o, thermo(8));
      check("rs_mid_busy", busy_o, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("rs_state", state_o, '0);
      check("rs_busy", busy_o, 0);
      check("rs_en", en_o, 4'h0);
      check("rs_frame", frame_ok_o, 0);
      check("rs_ctap", chain_tap_o, 8'h00);
      check("rs_stap", state_tap_o, 8'h00);
      #10;
      rst_n = 1'b1;
      tick();
      check("rs_en1", en_o, 4'h0);
      check("rs_busy1", busy_o, 0);
      tick();
      check("rs_en2", en_o, 4'hF);
      check("rs_state2", state_o, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
